// File: rtl/sfq_toggle_deserializer.sv
// Deserializer for toggle-encoded SFQ pulse streams: one bit per strobe window,
// WIDTH bits per word, delivered through a one-deep valid/ready output register.
module sfq_toggle_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       strb,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       overflow,
  output logic                       multi_pulse
);

  localparam int CW = $clog2(WIDTH + 1);

  // Output handshake: a word is transferred on any rising edge where
  // out_valid & out_ready; out_data is stable while out_valid is high and not accepted.

  logic             in_q, strb_q;
  logic             hit_q, hit_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             multi_pulse_q, multi_pulse_d;

  logic             in_evt, strb_evt, bit_v, complete;
  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] word;

  assign in_evt   = in ^ in_q;
  assign strb_evt = strb ^ strb_q;
  // A pulse arriving on the strobe edge itself still belongs to the closing window.
  assign bit_v    = hit_q | in_evt;
  assign complete = strb_evt && (bit_cnt_q == CW'(WIDTH - 1));
  assign pos      = MSB_FIRST ? (CW'(WIDTH - 1) - bit_cnt_q) : bit_cnt_q;

  always_comb begin
    word = shreg_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (pos == CW'(i)) word[i] = bit_v;
    end
  end

  always_comb begin
    hit_d         = hit_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    overflow_d    = overflow_q;
    multi_pulse_d = multi_pulse_q;

    if (strb_evt) begin
      hit_d = 1'b0;
    end else if (in_evt) begin
      hit_d = 1'b1;
      if (hit_q) multi_pulse_d = 1'b1;
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (strb_evt) begin
      if (complete) begin
        bit_cnt_d = '0;
        shreg_d   = '0;
        if (!out_valid_q || out_ready) begin
          out_data_d  = word;
          out_valid_d = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        shreg_d   = word;
      end
    end
  end

  always_ff @(posedge clk) begin
    // Edge-detect history tracks the inputs through reset so release is event-free.
    in_q   <= in;
    strb_q <= strb;
    if (rst) begin
      hit_q         <= 1'b0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      overflow_q    <= 1'b0;
      multi_pulse_q <= 1'b0;
    end else begin
      hit_q         <= hit_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      overflow_q    <= overflow_d;
      multi_pulse_q <= multi_pulse_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign bit_cnt     = bit_cnt_q;
  assign overflow    = overflow_q;
  assign multi_pulse = multi_pulse_q;

endmodule

// File: doc/sfq_toggle_deserializer.md
Name: sfq_toggle_deserializer

Overview:
- Downstream consumer of the RSFQ D flip-flop (DFFT) cell's output stream, clocked synchronously.
- Decodes toggle-encoded SFQ pulses: every transition of a line is one pulse.
  - `in` carries the DFFT output.
  - `strb` carries the DFFT clock, i.e. the bit-window boundary.
- Each window becomes one data bit. WIDTH bits are packed into a word, handed off over a valid/ready interface.
- Protocol errors are flagged for the verification environment.

Parameters:
- WIDTH, 8, bits per output word (2..32).
- MSB_FIRST, 0, 0 = first received bit lands in data[0]; 1 = first bit lands in data[WIDTH-1].

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  toggle-encoded SFQ data (DFFT out).
- strb  input  1  toggle-encoded SFQ window strobe (DFFT clk).
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds an undelivered word.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready at a rising edge.
- bit_cnt  output  $clog2(WIDTH+1)  bits collected in the current, incomplete word.
- overflow  output  1  sticky: a completed word was dropped because the output register was full.
- multi_pulse  output  1  sticky: more than one in pulse occurred within one window.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Edge detect:
  - Registers in_q and strb_q.
  - in_evt = in ^ in_q; strb_evt = strb ^ strb_q, evaluated at each rising edge.
  - in_q <= in and strb_q <= strb every edge, including during reset, so reset never creates spurious events.
- Window state:
  - Flag hit is set by in_evt and cleared by strb_evt.
  - At a strb_evt edge: bit = hit | in_evt. A pulse coincident with the strobe belongs to the closing window.
  - After that edge, hit = 0. The same-cycle in_evt does not carry into the next window.
- Double pulse: in_evt while hit = 1 (no strb_evt that edge) sets multi_pulse. Bit value stays 1.
- Shift:
  - On strb_evt, the bit is inserted per MSB_FIRST and bit_cnt increments.
  - At bit_cnt = WIDTH-1 with strb_evt, the word completes and bit_cnt wraps to 0 on that edge.
- Output register (one deep):
  - A completed word loads out_data and sets out_valid at the same edge, if out_valid = 0 or (out_valid & out_ready) at that edge.
  - Simultaneous accept and completion: the new word replaces the old one and out_valid stays 1.
  - Otherwise the word is dropped, overflow is set, and out_data is unchanged.
- Latency: the strobe edge that closes the final bit makes out_valid visible immediately after that edge (0 extra cycles).
- Acceptance: out_valid & out_ready at an edge with no completion clears out_valid. out_data holds its value.
- Reset (at any point, mid-word included):
  - hit, bit_cnt, out_data, out_valid, overflow and multi_pulse all go to 0.
  - The partial word is discarded. in_q and strb_q are still loaded from the inputs.
- Sticky flags clear only on rst.
- in or strb toggling twice between edges is invisible. This is the caller's responsibility; no flag is raised.

Test Plan:
- WIDTH=4, MSB_FIRST=0, out_ready=1:
  - pulses in windows 1 and 3 (in toggles, then strb toggles, x4) -> single out_valid cycle, out_data=4'b0101.
  - bit_cnt steps 1,2,3,0.
- Coincident in and strb toggle in the same cycle, 4 windows, pulses only on the coincident bit 0 -> out_data=4'b0001. The next window reads 0 (hit not carried).
- Two in toggles in one window -> multi_pulse=1 stays set, that bit=1. A later clean word is still delivered correctly.
- out_ready=0, send two full words (0xA then 0x3 at WIDTH=4):
  - out_data holds 4'hA and overflow=1.
  - Raise out_ready -> out_valid clears after one edge.
- out_valid=1 with out_ready=1 on the exact edge the next word completes -> out_valid stays 1, out_data updates to the new word, overflow stays 0.
- Assert rst after 2 bits of a word:
  - all outputs read 0 the edge after.
  - 4 fresh bits 1,1,0,0 -> out_data=4'b0011.
  - No spurious bit from in/strb levels held during reset.
